// File: rtl/param_stack.sv
// Parametrised LIFO return-address stack with registered top-of-stack, count, flags and sticky faults.
// Latency: one cycle; every output is registered or decoded from registered count, with no input-to-output path.
// Backpressure: none; a push when full or a pop when empty is refused, sets a sticky flag and freezes the stack until clear/rst.
module param_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic             fault
);

    // Address width for the storage array; count is one bit wider when DEPTH is a power of two.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

    logic [WIDTH-1:0] mem_q [DEPTH];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             ovf_q,   ovf_d;
    logic             udf_q,   udf_d;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    below_idx;
    logic             is_empty;
    logic             is_full;

    // push_idx is only used when not full, top_idx only when not empty,
    // below_idx only when count >= 2, so none of them ever reaches DEPTH.
    assign push_idx  = AW'(count_q);
    assign top_idx   = AW'(count_q - CNT_W'(1));
    assign below_idx = AW'(count_q - CNT_W'(2));
    assign is_empty  = (count_q == '0);
    assign is_full   = (count_q == CNT_W'(DEPTH));

    // Next-state decode: clear beats a frozen FAULT state, which beats push/pop.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        wr_en   = 1'b0;
        wr_addr = push_idx;

        if (clear) begin
            state_d = ST_RUN;
            count_d = '0;
            data_d  = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else if (state_q == ST_RUN) begin
            unique case ({push, pop})
                2'b10: begin
                    if (is_full) begin
                        ovf_d   = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = push_idx;
                        count_d = count_q + CNT_W'(1);
                        data_d  = data_in;
                    end
                end
                2'b01: begin
                    if (is_empty) begin
                        udf_d   = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                        // The entry below the popped one becomes the new top.
                        data_d  = (count_q >= CNT_W'(2)) ? mem_q[below_idx] : '0;
                    end
                end
                2'b11: begin
                    wr_en  = 1'b1;
                    data_d = data_in;
                    if (is_empty) begin
                        // Nothing to replace: store as a push but still flag the bad pop.
                        wr_addr = push_idx;
                        count_d = CNT_W'(1);
                        udf_d   = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        wr_addr = top_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control and output registers, including the RUN/FAULT state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            count_q <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Entry storage; contents are meaningless above count, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    assign data_out  = data_q;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = udf_q;
    assign fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_param_stack.sv
// Bench for param_stack: a 16x16 and a 12x5 instance checked against a queue-based LIFO model.
// Each step records the expected post-edge outputs in a scoreboard and compares them 1 time unit after the edge.
// Directed scenarios from the plan plus a short random run on the 16-deep instance.
module tb_param_stack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        push_a, pop_a, clr_a;
    logic [15:0] din_a, dout_a;
    logic [4:0]  cnt_a;
    logic        emp_a, full_a, ovf_a, udf_a, flt_a;

    logic        push_b, pop_b, clr_b;
    logic [11:0] din_b, dout_b;
    logic [2:0]  cnt_b;
    logic        emp_b, full_b, ovf_b, udf_b, flt_b;

    param_stack #(.WIDTH(16), .DEPTH(16)) u_dut_a (
        .clk(clk), .rst(rst), .push(push_a), .pop(pop_a), .clear(clr_a),
        .data_in(din_a), .data_out(dout_a), .count(cnt_a), .empty(emp_a),
        .full(full_a), .overflow(ovf_a), .underflow(udf_a), .fault(flt_a)
    );

    param_stack #(.WIDTH(12), .DEPTH(5)) u_dut_b (
        .clk(clk), .rst(rst), .push(push_b), .pop(pop_b), .clear(clr_b),
        .data_in(din_b), .data_out(dout_b), .count(cnt_b), .empty(emp_b),
        .full(full_b), .overflow(ovf_b), .underflow(udf_b), .fault(flt_b)
    );

    typedef struct {
        int          sel;
        logic [4:0]  cnt;
        logic [15:0] dout;
        logic        emp, full, ovf, udf, flt;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] stk_a[$];
    logic [15:0] stk_b[$];
    bit          m_ovf[2];
    bit          m_udf[2];
    bit          m_flt[2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        stk_a.delete();
        stk_b.delete();
        for (int i = 0; i < 2; i++) begin
            m_ovf[i] = 1'b0;
            m_udf[i] = 1'b0;
            m_flt[i] = 1'b0;
        end
    endtask

    // Behavioural LIFO model; records the expected outputs after this edge.
    task automatic model(input int sel, input bit p, input bit q, input bit c, input logic [15:0] d);
        logic [15:0] s[$];
        logic [15:0] mask;
        int          dep;
        exp_t        e;
        if (sel == 0) s = stk_a; else s = stk_b;
        dep  = (sel == 0) ? 16 : 5;
        mask = (sel == 0) ? 16'hFFFF : 16'h0FFF;
        if (c) begin
            s.delete();
            m_ovf[sel] = 1'b0;
            m_udf[sel] = 1'b0;
            m_flt[sel] = 1'b0;
        end else if (!m_flt[sel]) begin
            if (p && !q) begin
                if (s.size() == dep) begin
                    m_ovf[sel] = 1'b1;
                    m_flt[sel] = 1'b1;
                end else begin
                    s.push_back(d & mask);
                end
            end else if (q && !p) begin
                if (s.size() == 0) begin
                    m_udf[sel] = 1'b1;
                    m_flt[sel] = 1'b1;
                end else begin
                    void'(s.pop_back());
                end
            end else if (p && q) begin
                if (s.size() == 0) begin
                    s.push_back(d & mask);
                    m_udf[sel] = 1'b1;
                    m_flt[sel] = 1'b1;
                end else begin
                    s[s.size()-1] = d & mask;
                end
            end
        end
        if (sel == 0) stk_a = s; else stk_b = s;
        e.sel  = sel;
        e.cnt  = 5'(s.size());
        e.dout = (s.size() == 0) ? 16'h0 : s[s.size()-1];
        e.emp  = (s.size() == 0);
        e.full = (s.size() == dep);
        e.ovf  = m_ovf[sel];
        e.udf  = m_udf[sel];
        e.flt  = m_flt[sel];
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [15:0] dout;
        logic [4:0]  cnt;
        logic        emp, full, ovf, udf, flt;
        string       n;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        if (e.sel == 0) begin
            n = "a"; dout = dout_a; cnt = cnt_a; emp = emp_a; full = full_a;
            ovf = ovf_a; udf = udf_a; flt = flt_a;
        end else begin
            n = "b"; dout = {4'h0, dout_b}; cnt = {2'b00, cnt_b}; emp = emp_b; full = full_b;
            ovf = ovf_b; udf = udf_b; flt = flt_b;
            chk("b.dout_known", {31'd0, $isunknown(dout_b)}, 32'd0);
        end
        chk({n, ".count"},     {27'd0, cnt},  {27'd0, e.cnt});
        chk({n, ".data_out"},  {16'd0, dout}, {16'd0, e.dout});
        chk({n, ".empty"},     {31'd0, emp},  {31'd0, e.emp});
        chk({n, ".full"},      {31'd0, full}, {31'd0, e.full});
        chk({n, ".overflow"},  {31'd0, ovf},  {31'd0, e.ovf});
        chk({n, ".underflow"}, {31'd0, udf},  {31'd0, e.udf});
        chk({n, ".fault"},     {31'd0, flt},  {31'd0, e.flt});
    endtask

    // One clocked operation on the selected instance, then scoreboard check.
    task automatic step(input int sel, input bit p, input bit q, input bit c, input logic [15:0] d);
        if (sel == 0) begin
            push_a = p; pop_a = q; clr_a = c; din_a = d;
        end else begin
            push_b = p; pop_b = q; clr_b = c; din_b = d[11:0];
        end
        model(sel, p, q, c, d);
        @(posedge clk);
        #1;
        push_a = 1'b0; pop_a = 1'b0; clr_a = 1'b0;
        push_b = 1'b0; pop_b = 1'b0; clr_b = 1'b0;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] vals_b[5];
        rst = 1'b1;
        push_a = 1'b0; pop_a = 1'b0; clr_a = 1'b0; din_a = '0;
        push_b = 1'b0; pop_b = 1'b0; clr_b = 1'b0; din_b = '0;
        model_reset();
        #12;
        chk("rst.a.count", {27'd0, cnt_a}, 32'd0);
        chk("rst.a.data_out", {16'd0, dout_a}, 32'd0);
        chk("rst.a.empty", {31'd0, emp_a}, 32'd1);
        chk("rst.b.count", {29'd0, cnt_b}, 32'd0);
        chk("rst.a.fault", {31'd0, flt_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic push/pop.
        step(0, 1, 0, 0, 16'h01A3);
        step(0, 1, 0, 0, 16'h02B4);
        step(0, 0, 1, 0, 16'h0);
        step(0, 0, 1, 0, 16'h0);

        // Fill, overflow, pops frozen, clear.
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 16'h0100 + 16'(i));
        step(0, 1, 0, 0, 16'h0999);
        step(0, 0, 1, 0, 16'h0);
        step(0, 0, 1, 0, 16'h0);
        step(0, 0, 0, 1, 16'h0);

        // Underflow, frozen push, clear and recover.
        step(0, 0, 1, 0, 16'h0);
        step(0, 1, 0, 0, 16'h0123);
        step(0, 0, 0, 1, 16'h0);
        step(0, 1, 0, 0, 16'h0123);
        step(0, 0, 0, 1, 16'h0);

        // Replace top, then replace at full.
        step(0, 1, 0, 0, 16'h0AAA);
        step(0, 1, 1, 0, 16'h0BBB);
        step(0, 0, 1, 0, 16'h0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 16'h0200 + 16'(i));
        step(0, 1, 1, 0, 16'h0CCC);
        step(0, 0, 1, 0, 16'h0);
        step(0, 0, 1, 0, 16'h0);
        step(0, 0, 0, 1, 16'h0);

        // Simultaneous push/pop on an empty stack.
        step(0, 1, 1, 0, 16'h0DDD);
        step(0, 0, 1, 0, 16'h0);
        step(0, 0, 0, 1, 16'h0);

        // Asynchronous reset mid-cycle with push held high.
        step(0, 1, 0, 0, 16'h0011);
        step(0, 1, 0, 0, 16'h0022);
        step(0, 1, 0, 0, 16'h0033);
        push_a = 1'b1; din_a = 16'h0044;
        #2;
        rst = 1'b1;
        #1;
        chk("arst.a.count", {27'd0, cnt_a}, 32'd0);
        chk("arst.a.data_out", {16'd0, dout_a}, 32'd0);
        chk("arst.a.empty", {31'd0, emp_a}, 32'd1);
        push_a = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 16'h0);
        step(0, 0, 1, 0, 16'h0);
        step(0, 0, 0, 1, 16'h0);

        // 12-bit x 5-deep instance: fill, LIFO drain, overflow.
        vals_b[0] = 16'h0FFF; vals_b[1] = 16'h0001; vals_b[2] = 16'h0555;
        vals_b[3] = 16'h0AAA; vals_b[4] = 16'hF123;
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, vals_b[i]);
        step(1, 1, 1, 0, 16'h0777);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 16'h0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 16'h0300 + 16'(i));
        step(1, 0, 0, 1, 16'h0);

        // Short random mix on the 16-deep instance.
        for (int i = 0; i < 120; i++) begin
            int r;
            r = $urandom_range(0, 15);
            step(0, r[0] | r[2], r[1], (r == 15), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO return-address stack, successor to the fixed 16-bit subroutine stack used by the CHIP-8 CALL/RET path.
- Generalised in width and depth, with a registered top-of-stack output, occupancy count, full/empty flags, replace-on-simultaneous push/pop, and sticky overflow/underflow faults.
- Sits between the instruction decoder (push on CALL, pop on RET) and the PC logic. The PC reads the return address from data_out.

Parameters:
- WIDTH, 16: entry width in bits (CHIP-8 addresses are 12 bits; 16 leaves headroom).
- DEPTH, 16: number of entries. Must be ≥2. Non-power-of-two values are legal.
- CNT_W, $clog2(DEPTH+1): derived localparam; width of count. Not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  push data_in this cycle.
- pop  input  1  pop top entry this cycle.
- clear  input  1  synchronous flush: empties the stack and clears faults.
- data_in  input  WIDTH  value to push.
- data_out  output  WIDTH  registered copy of the current top entry; 0 when empty.
- count  output  CNT_W  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: a push was attempted while full with no pop.
- underflow  output  1  sticky: a pop was attempted while empty.
- fault  output  1  high in FAULT state (overflow | underflow).

Behaviour:
- Reset (rst high, asynchronous): count=0, data_out=0, overflow=0, underflow=0, state=RUN. Memory contents are don't-care. Reset mid-operation discards everything.
- All other updates happen on the rising clk edge. empty and full are decoded combinationally from count.
- Priority, highest first: clear, then FAULT hold, then push/pop decode.
- clear=1: count→0, data_out→0, overflow/underflow→0, state→RUN. push and pop are ignored that cycle.
- State RUN, with op decoded from {push, pop}:
  - 00: hold.
  - 10, not full: mem[count]←data_in; count+1; data_out←data_in.
  - 10, full: no write; count and data_out unchanged; overflow←1; state→FAULT.
  - 01, not empty: count-1; data_out←mem[count-2] if count≥2, else 0. The popped value is the data_out seen before the edge, so the consumer samples data_out in the same cycle it asserts pop.
  - 01, empty: no change; underflow←1; state→FAULT.
  - 11, not empty: replace top. mem[count-1]←data_in; count unchanged; data_out←data_in. Legal when full; no overflow.
  - 11, empty: behaves as a push; underflow←1; state→FAULT. The pushed entry is still stored (count=1, data_out=data_in).
- State FAULT: push and pop are ignored. Contents, count and data_out are frozen. The sticky flags hold. Exits only via clear or rst.
- Latency: data_out, count and flags reflect an operation one cycle after the edge that accepts it. There is no combinational path from push/pop/data_in to any output.
- data_in is truncated/used exactly WIDTH bits; no sign handling.
- Memory: DEPTH×WIDTH register array. The write address is count (push) or count-1 (replace). No address ever equals DEPTH.

Test Plan:
- Reset, then push 0x01A3 then 0x02B4 on separate cycles → count=2, data_out=0x02B4. Pop → data_out=0x01A3, count=1. Pop → data_out=0, empty=1, no fault.
- Fill with DEPTH=16 pushes of 0x100+i → full=1, count=16, data_out=0x10F. A 17th push → overflow=1, fault=1, data_out stays 0x10F. Further pops are ignored (count stays 16). clear → count=0, flags 0.
- Empty stack, pop → underflow=1, fault=1, count=0. Then push 0x0123 → ignored, count=0. clear, then push 0x0123 → count=1, data_out=0x0123.
- Push 0x0AAA, then push=pop=1 with data_in=0x0BBB → count=1, data_out=0x0BBB. Pop → empty=1, data_out=0. Repeat replace at full → no overflow, count=16.
- Push 3 values, assert rst asynchronously mid-cycle with push high → outputs go to 0 immediately, before the next edge. After release, count=0 and the old entries are unreachable.
- Parameter sweep WIDTH=12, DEPTH=5: push 5 values (0xFFF, 0x001, ...) → full at count=5, CNT_W=3. Pop all 5 → LIFO order is checked against a bench model. No X on data_out at any point.
